// File: rtl/lifo_stack_if.sv
// Request/response bundle for lifo_stack. The producer/consumer side uses the
// master modport; the stack itself uses the slave modport.
interface lifo_stack_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic             clear;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, push, pop, clear, err_clr,
    input  data_out, out_valid, top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  data_in, push, pop, clear, err_clr,
    output data_out, out_valid, top, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with occupancy count, combinational top-of-stack
// peek, registered pop output with valid strobe, synchronous clear and sticky
// overflow/underflow flags. A simultaneous push and pop on a non-empty stack
// swaps the top entry; on an empty stack it acts as a plain push.
module lifo_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rstN,
  lifo_stack_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] data_out_q;
  logic             out_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             is_full;
  logic             is_empty;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    free_idx;
  logic [WIDTH-1:0] top_val;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic             rd_en;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             ovf_set;
  logic             udf_set;

  assign is_full  = (count_q == COUNT_MAX);
  assign is_empty = (count_q == '0);
  // top_idx is only meaningful when the stack is non-empty; free_idx only when not full.
  assign top_idx  = AW'(count_q - CW'(1));
  assign free_idx = AW'(count_q);
  assign top_val  = is_empty ? '0 : mem[top_idx];

  // Decode the request into memory, pointer and error actions; clear overrides all.
  always_comb begin
    // NOTE: every decode output is given a default first so no latch is inferred.
    wr_en   = 1'b0;
    wr_idx  = free_idx;
    rd_en   = 1'b0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (!bus.clear) begin
      if (bus.push && bus.pop && !is_empty) begin
        // Swap: read the old top out and overwrite it in place.
        rd_en  = 1'b1;
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (bus.push) begin
        // Also covers push+pop on an empty stack, which degrades to a push.
        if (!is_full) begin
          wr_en   = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end else if (bus.pop) begin
        if (!is_empty) begin
          rd_en   = 1'b1;
          cnt_dec = 1'b1;
        end else begin
          udf_set = 1'b1;
        end
      end
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; entries above count are never observable.
    if (wr_en) begin
      mem[wr_idx] <= bus.data_in;
    end
  end

  // Occupancy pointer, pop output register and valid strobe.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= rd_en;
      if (rd_en) begin
        data_out_q <= top_val;
      end
      if (bus.clear) begin
        count_q <= '0;
      end else if (cnt_inc) begin
        count_q <= count_q + CW'(1);
      end else if (cnt_dec) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end
      if (udf_set) begin
        underflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.top       = top_val;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised LIFO stack: the next-generation replacement for the fixed 4-bit × 8-entry stack in the lab datapath. It adds configurable width and depth, an occupancy count, a combinational top-of-stack peek, a registered pop output with a valid strobe, a synchronous clear, and sticky overflow/underflow error flags. It sits between a producer issuing `push` and a consumer issuing `pop`, in a single clock domain.

## Interface
- `WIDTH`, default 4: data word width in bits, ≥1.
- `DEPTH`, default 8: number of entries, ≥2, any integer (power of two not required).
- Local `CW` = $clog2(DEPTH+1): width of `count`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  word to push.
- `push`  in  1  push request, sampled at the rising edge.
- `pop`  in  1  pop request, sampled at the rising edge.
- `clear`  in  1  synchronous flush: empties the stack.
- `err_clr`  in  1  synchronous clear of the sticky error flags.
- `data_out`  out  WIDTH  registered; last popped word.
- `out_valid`  out  1  one-cycle strobe: `data_out` was updated by an accepted pop.
- `top`  out  WIDTH  combinational peek of the top entry; 0 when empty.
- `count`  out  CW  number of stored entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.

## Operation
- Storage: DEPTH × WIDTH array, not reset. Pointer `count` addresses the next free slot; top entry is `mem[count-1]`.
- Per-edge priority: `clear`, then the push/pop decode below. On `clear`, `count` → 0, `out_valid` → 0, `data_out` holds, and push/pop are ignored (no error flags set).
- push=1, pop=0, not full: `mem[count]` ← `data_in`; `count` += 1.
- push=1, pop=0, full: ignored; `overflow` ← 1.
- push=0, pop=1, not empty: `data_out` ← `mem[count-1]`; `count` −= 1; `out_valid` = 1.
- push=0, pop=1, empty: ignored; `data_out` holds; `underflow` ← 1.
- push=1, pop=1, not empty (including full): swap. `data_out` ← old top; `mem[count-1]` ← `data_in`; `count` unchanged; `out_valid` = 1. No error flags.
- push=1, pop=1, empty: treated as a plain push. `count` → 1; `out_valid` = 0; `underflow` is not set.
- `out_valid` is 0 in every cycle without an accepted pop or swap.
- `err_clr` clears both sticky flags. If an error occurs in the same cycle, the set wins.
- `full`, `empty` and `top` are decoded combinationally from the registered `count` and `mem`.
- Arithmetic: `count` never wraps. It saturates logically at 0 and DEPTH through the reject rules above.

## Timing
- Reset (asynchronous assert, mid-operation included):
  - `count`=0, `data_out`=0, `out_valid`=0, `overflow`=0, `underflow`=0.
  - Hence `empty`=1, `full`=0, `top`=0.
  - Memory contents are undefined but unobservable.
- Pop latency: one cycle. Pop is sampled at edge N; `data_out`/`out_valid` are valid after edge N, and `out_valid` deasserts after edge N+1 unless another pop is accepted.
- Push visibility: data pushed at edge N appears on `top` and in `count` immediately after edge N.
- Back-to-back push or pop on consecutive cycles is supported at full rate; there are no bubbles.
- Error flags rise the cycle after the offending request and stay high until `err_clr` or reset.

## Test plan
- Reset, then push 1,2,…,8 (WIDTH=4, DEPTH=8):
  - `count` steps 1..8; `full`=1 after the 8th edge; `top`=8.
  - A 9th push of 9 → `overflow`=1, `count`=8, `top`=8.
- From full, pop 8 times:
  - `data_out` sequence 8,7,…,1, each with a one-cycle `out_valid`; `empty`=1 at the end.
  - A 9th pop → `underflow`=1, `data_out` stays 1, `out_valid`=0.
- Stack holding 3,5: push=pop=1 with `data_in`=A → `data_out`=5, `out_valid`=1, `count`=2, `top`=A.
  - Repeat with the stack full → same swap, `overflow` stays 0.
- Empty stack: push=pop=1 with `data_in`=C → `count`=1, `top`=C, `out_valid`=0, `underflow`=0.
- Errors and clear:
  - Stack at `count`=5 with `underflow` set: `clear`=1 with push=1 → `count`=0, `data_out` unchanged, flags unchanged.
  - `err_clr`=1 together with a pop on empty → `underflow` stays 1.
  - `err_clr` alone → `underflow`=0.
- Assert `rstN`=0 asynchronously mid-pop (count=4) → all outputs at reset values before the next edge.
  - Repeat the push/pop scenarios with WIDTH=16, DEPTH=5: `count` width 3, full at 5.
